// File: rtl/fir_decim_fifo_pkg.sv
// Shared constants and helpers for the FIR back-end stages.
package fir_pkg;

    localparam int FIR_WIDTH = 8;
    localparam int FIR_DECIM = 4;
    localparam int FIR_DEPTH = 8;

    // Ceiling log2, usable in constant expressions (parameters, port widths).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_decim_fifo_if.sv
// Sample-in / decimated-sample-out bus of fir_decim_fifo.
// Handshake: out_data transfers on a cycle where out_valid && out_ready; in_en has no back-pressure.
interface fir_decim_fifo_if
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int DEPTH = FIR_DEPTH
);
    logic [WIDTH-1:0]      Din;
    logic                  in_en;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [clog2(DEPTH):0] level;
    logic                  overflow;

    modport master (
        output Din, in_en, out_ready,
        input  out_data, out_valid, level, overflow
    );

    modport slave (
        input  Din, in_en, out_ready,
        output out_data, out_valid, level, overflow
    );
endinterface

// File: rtl/fir_decim_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; read data is forced to 0 while empty.
module sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int DEPTH = FIR_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty && !clear;
    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop) && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; the empty mask hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/fir_decim_fifo.sv
// Integrate-and-dump decimator feeding a show-ahead FIFO with sticky overflow.
// Define FIRDEC_DROPCNT_EN to add the saturating drop_cnt output.
module fir_decim_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int DECIM = FIR_DECIM,
    parameter int DEPTH = FIR_DEPTH
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                clear,
    fir_decim_fifo_if.slave     bus
`ifdef FIRDEC_DROPCNT_EN
    ,
    output logic [7:0]          drop_cnt
`endif
);
    localparam int SH = clog2(DECIM);
    localparam int AW = WIDTH + SH;
    localparam logic [SH-1:0] LAST_PHASE = SH'(DECIM - 1);

    logic [SH-1:0]    phase_q, phase_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [AW-1:0]    sum;
    logic [WIDTH-1:0] dump_val;
    logic             accept, dump, pop, drop;
    logic             fifo_full, fifo_empty;

    assign accept   = bus.in_en && !clear;
    assign sum      = (phase_q == '0) ? AW'(bus.Din) : acc_q + AW'(bus.Din);
    assign dump     = accept && (phase_q == LAST_PHASE);
    assign dump_val = WIDTH'(sum >> SH);
    assign pop      = bus.out_valid && bus.out_ready;
    assign drop     = dump && fifo_full && !pop;

    // DECIM is a power of two, so the phase counter wraps to 0 naturally.
    always_comb begin
        phase_d = phase_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (clear) begin
            phase_d = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (accept) begin
                phase_d = phase_q + SH'(1);
                acc_d   = sum;
            end
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (reset_n),
        .clear (clear),
        .push  (dump),
        .pop   (pop),
        .wdata (dump_val),
        .rdata (bus.out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (bus.level)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.overflow  = ovf_q;

`ifdef FIRDEC_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear)                             drop_cnt_d = '0;
        else if (drop && drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo at default parameters (WIDTH=8, DECIM=4, DEPTH=8).
module tb_fir_decim_fifo;
    import fir_pkg::*;

    logic CLK;
    logic reset_n;
    logic clear;
    int   n_tests;
    int   n_fail;

    fir_decim_fifo_if #(.WIDTH(8), .DEPTH(8)) bus ();

`ifdef FIRDEC_DROPCNT_EN
    logic [7:0] drop_cnt;
`endif

    fir_decim_fifo #(
        .WIDTH (8),
        .DECIM (4),
        .DEPTH (8)
    ) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .clear    (clear),
        .bus      (bus)
`ifdef FIRDEC_DROPCNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge, then settle 1 time unit so checks sample away from the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic send(input logic [7:0] v);
        bus.Din   = v;
        bus.in_en = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        bus.in_en = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_group(input logic [7:0] v);
        for (int i = 0; i < 4; i++) send(v);
        bus.in_en = 1'b0;
    endtask

    task automatic pop_one();
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        clear         = 1'b0;
        bus.Din       = '0;
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_level",     32'(bus.level),     0);
        check("rst_overflow",  32'(bus.overflow),  0);
        check("rst_out_data",  32'(bus.out_data),  0);
`ifdef FIRDEC_DROPCNT_EN
        check("rst_drop_cnt",  32'(drop_cnt),      0);
`endif
        #2 reset_n = 1'b1;
        step();

        // Average 10,20,30,40 -> 25, visible one edge after the 40 sample
        send(8'd10); send(8'd20); send(8'd30);
        check("avg_no_early_valid", 32'(bus.out_valid), 0);
        send(8'd40);
        bus.in_en = 1'b0;
        check("avg_valid", 32'(bus.out_valid), 1);
        check("avg_data",  32'(bus.out_data),  25);
        check("avg_level", 32'(bus.level),     1);
        // Held while out_ready is low
        idle(2);
        check("avg_hold_data",  32'(bus.out_data), 25);
        check("avg_hold_level", 32'(bus.level),    1);
        pop_one();
        check("avg_pop_valid", 32'(bus.out_valid), 0);
        check("avg_pop_data",  32'(bus.out_data),  0);
        check("avg_pop_level", 32'(bus.level),     0);

        // Full-scale and truncation
        send_group(8'd255);
        check("sat_data", 32'(bus.out_data), 255);
        pop_one();
        send(8'd1); send(8'd1); send(8'd1); send(8'd2);
        bus.in_en = 1'b0;
        check("trunc_data", 32'(bus.out_data), 1);
        pop_one();
        check("trunc_pop_level", 32'(bus.level), 0);

        // Gapped input: 8 with 3 idle cycles between samples
        for (int i = 0; i < 4; i++) begin
            send(8'd8);
            idle(3);
            if (i < 3) check($sformatf("gap_level_%0d", i), 32'(bus.level), 0);
        end
        check("gap_data",  32'(bus.out_data), 8);
        check("gap_level", 32'(bus.level),    1);
        idle(4);
        check("gap_no_extra", 32'(bus.level), 1);
        pop_one();

        // Overflow: 9 groups, averages 100..108, no consumer
        for (int g = 0; g < 8; g++) send_group(8'(100 + g));
        check("ovf_level_8",   32'(bus.level),    8);
        check("ovf_not_yet",   32'(bus.overflow), 0);
        send_group(8'd108);
        check("ovf_level",     32'(bus.level),    8);
        check("ovf_flag",      32'(bus.overflow), 1);
`ifdef FIRDEC_DROPCNT_EN
        check("ovf_drop_cnt",  32'(drop_cnt),     1);
`endif
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_order_%0d", i), 32'(bus.out_data), 32'(100 + i));
            pop_one();
        end
        check("ovf_drained",   32'(bus.level),    0);
        check("ovf_sticky",    32'(bus.overflow), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("ovf_cleared",   32'(bus.overflow), 0);
`ifdef FIRDEC_DROPCNT_EN
        check("drop_cnt_cleared", 32'(drop_cnt),  0);
`endif

        // Full FIFO with push and pop on the dump cycle
        for (int g = 0; g < 8; g++) send_group(8'(20 + g));
        check("fpp_full", 32'(bus.level), 8);
        send(8'd28); send(8'd28); send(8'd28);
        bus.out_ready = 1'b1;
        send(8'd28);
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b0;
        check("fpp_level",    32'(bus.level),    8);
        check("fpp_overflow", 32'(bus.overflow), 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fpp_order_%0d", i), 32'(bus.out_data), 32'(21 + i));
            pop_one();
        end
        check("fpp_drained", 32'(bus.level), 0);

        // Asynchronous reset mid-group with data buffered
        send_group(8'd9);
        send(8'd50); send(8'd60);
        bus.in_en = 1'b0;
        check("mid_pre_level", 32'(bus.level), 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 0);
        check("arst_level", 32'(bus.level),     0);
        check("arst_data",  32'(bus.out_data),  0);
        #1 reset_n = 1'b1;
        step();
        send_group(8'd4);
        check("arst_regroup_data",  32'(bus.out_data), 4);
        check("arst_regroup_level", 32'(bus.level),    1);
        pop_one();

        // Clear with level=3, partial group, and a concurrent in_en / pop
        send_group(8'd1); send_group(8'd2); send_group(8'd3);
        check("clr_pre_level", 32'(bus.level), 3);
        send(8'd200); send(8'd200);
        clear         = 1'b1;
        bus.Din       = 8'd200;
        bus.in_en     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        clear         = 1'b0;
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b0;
        check("clr_level", 32'(bus.level),     0);
        check("clr_valid", 32'(bus.out_valid), 0);
        check("clr_data",  32'(bus.out_data),  0);
        // Fresh group after clear must average only new samples
        send_group(8'd6);
        check("clr_regroup_data",  32'(bus.out_data), 6);
        check("clr_regroup_level", 32'(bus.level),    1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
